// File: rtl/rvsteel_input_conditioner_pkg.sv
// rvsteel_input_conditioner_pkg: width and cycle-count helpers shared by the input conditioner
package rvsteel_input_conditioner_pkg;
  function automatic int clog2(longint value);
    int r = 0;
    while ((64'd1 << r) < value) r++;
    return r;
  endfunction
  function automatic int debounce_cycles(longint frequency, longint time_us);
    longint c = frequency * time_us / 64'd1000000;
    return c < 1 ? 1 : int'(c);
  endfunction
  function automatic int long_press_cycles(longint frequency, longint time_ms);
    longint c = frequency / 64'd1000 * time_ms;
    return c < 1 ? 1 : int'(c);
  endfunction
endpackage

// File: rtl/rvsteel_input_conditioner_channel.sv
// rvsteel_input_conditioner_channel: one-bit synchroniser, debounce filter, edge pulses and hold counter (RVSTEEL_INPUT_CONDITIONER_LONG_PRESS_EN)
module rvsteel_input_conditioner_channel
  import rvsteel_input_conditioner_pkg::*;
#(
  parameter int   SYNC_STAGES       = 2,
  parameter int   DEBOUNCE_CYCLES   = 1,
  parameter int   LONG_PRESS_CYCLES = 1,
  parameter logic RESET_VALUE       = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic long_press
);
  localparam int CW = clog2(longint'(DEBOUNCE_CYCLES) + 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] count;
  logic s;
  assign s = sync[SYNC_STAGES-1];
  always_ff @(posedge clock) begin
    if (reset) begin
      sync  <= {SYNC_STAGES{RESET_VALUE}};
      level <= RESET_VALUE;
      count <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      rise <= 1'b0;
      fall <= 1'b0;
      if (s == level) count <= '0;
      else if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= s;
        count <= '0;
        rise  <= s;
        fall  <= ~s;
      end else count <= count + CW'(1);
    end
  end
`ifdef RVSTEEL_INPUT_CONDITIONER_LONG_PRESS_EN
  localparam int LW = clog2(longint'(LONG_PRESS_CYCLES) + 1);
  logic [LW-1:0] hold;
  always_ff @(posedge clock) begin
    if (reset || !level) begin
      hold       <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= hold == LW'(LONG_PRESS_CYCLES - 1);
      if (hold != LW'(LONG_PRESS_CYCLES)) hold <= hold + LW'(1);
    end
  end
`else
  assign long_press = 1'b0;
`endif
endmodule

// File: rtl/rvsteel_input_conditioner.sv
// rvsteel_input_conditioner: N-channel synchroniser/debouncer for board inputs (long press via RVSTEEL_INPUT_CONDITIONER_LONG_PRESS_EN)
module rvsteel_input_conditioner
  import rvsteel_input_conditioner_pkg::*;
#(
  parameter int                    NUM_INPUTS       = 2,
  parameter int                    CLOCK_FREQUENCY  = 50000000,
  parameter int                    DEBOUNCE_TIME_US = 10000,
  parameter int                    SYNC_STAGES      = 2,
  parameter logic [NUM_INPUTS-1:0] RESET_VALUE      = '0,
  parameter int                    LONG_PRESS_MS    = 1000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_INPUTS-1:0] inputs,
  output logic [NUM_INPUTS-1:0] level,
  output logic [NUM_INPUTS-1:0] rise,
  output logic [NUM_INPUTS-1:0] fall,
  output logic [NUM_INPUTS-1:0] long_press
);
  localparam int DEBOUNCE_CYCLES   = debounce_cycles(longint'(CLOCK_FREQUENCY), longint'(DEBOUNCE_TIME_US));
  localparam int LONG_PRESS_CYCLES = long_press_cycles(longint'(CLOCK_FREQUENCY), longint'(LONG_PRESS_MS));
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("rvsteel_input_conditioner: SYNC_STAGES must be 2..4");
  end
  if (NUM_INPUTS < 1 || NUM_INPUTS > 32) begin : g_bad_width
    $error("rvsteel_input_conditioner: NUM_INPUTS must be 1..32");
  end
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ch
    rvsteel_input_conditioner_channel #(
      .SYNC_STAGES      (SYNC_STAGES),
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .RESET_VALUE      (RESET_VALUE[i])
    ) u_ch (
      .clock     (clock),
      .reset     (reset),
      .raw       (inputs[i]),
      .level     (level[i]),
      .rise      (rise[i]),
      .fall      (fall[i]),
      .long_press(long_press[i])
    );
  end
endmodule

// File: tb/tb_rvsteel_input_conditioner.sv
// tb_rvsteel_input_conditioner: scoreboard bench, expected pulses queued at drive time and checked per cycle
module tb_rvsteel_input_conditioner;
  typedef struct {
    int         cyc;
    logic [1:0] r;
    logic [1:0] f;
    logic [1:0] lp;
  } ev_t;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] inputs = 2'b11;
  logic [1:0] level, rise, fall, long_press;
  int         cyc = 0;
  int         n_pass = 0;
  int         n_tot = 0;
  bit         mon_en = 1'b0;
  logic [1:0] lvl_exp = 2'b00;
  ev_t        q[$];
  int         e;

  rvsteel_input_conditioner #(
    .NUM_INPUTS      (2),
    .CLOCK_FREQUENCY (1000000),
    .DEBOUNCE_TIME_US(8),
    .SYNC_STAGES     (2),
    .RESET_VALUE     (2'b00),
    .LONG_PRESS_MS   (1)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .inputs    (inputs),
    .level     (level),
    .rise      (rise),
    .fall      (fall),
    .long_press(long_press)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] expv);
    n_tot++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, expv);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input int c, input logic [1:0] r, input logic [1:0] f, input logic [1:0] lp);
    ev_t ev;
    ev.cyc = c;
    ev.r = r;
    ev.f = f;
    ev.lp = lp;
    q.push_back(ev);
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      ev_t ev;
      logic [1:0] er, ef, elp;
      er = 2'b00;
      ef = 2'b00;
      elp = 2'b00;
      if (q.size() > 0 && q[0].cyc < cyc) begin
        chk("missed_event", 2'b00, 2'b11);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        ev = q.pop_front();
        er = ev.r;
        ef = ev.f;
        elp = ev.lp;
        lvl_exp = (lvl_exp | er) & ~ef;
      end
      chk("rise", rise, er);
      chk("fall", fall, ef);
      chk("level", level, lvl_exp);
      chk("long_press", long_press, elp);
    end
  end

  initial begin
    step(1);
    mon_en = 1'b1;
    step(2);
    reset = 1'b0;
    e = cyc;
    push(e + 10, 2'b11, 2'b00, 2'b00);
    step(14);

    inputs = 2'b00;
    step(4);
    reset = 1'b1;
    step(1);
    q.delete();
    lvl_exp = 2'b00;
    step(1);
    reset = 1'b0;
    step(15);

    inputs[0] = 1'b1;
    e = cyc;
    push(e + 10, 2'b01, 2'b00, 2'b00);
    step(15);
    inputs[0] = 1'b0;
    e = cyc;
    push(e + 10, 2'b00, 2'b01, 2'b00);
    step(15);

    inputs[0] = 1'b1;
    step(7);
    inputs[0] = 1'b0;
    step(20);

    for (int k = 0; k < 10; k++) begin
      inputs[1] = ~inputs[1];
      step(3);
    end
    inputs[1] = 1'b1;
    e = cyc;
    push(e + 10, 2'b10, 2'b00, 2'b00);
    step(15);

    inputs[0] = 1'b1;
    e = cyc;
    push(e + 10, 2'b01, 2'b00, 2'b00);
`ifdef RVSTEEL_INPUT_CONDITIONER_LONG_PRESS_EN
    push(e + 1010, 2'b00, 2'b00, 2'b01);
`endif
    step(1500);
    inputs = 2'b00;
    e = cyc;
    push(e + 10, 2'b00, 2'b11, 2'b00);
    step(15);

    mon_en = 1'b0;
    chk("pending_events", 2'(q.size() > 3 ? 3 : q.size()), 2'b00);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
